// File: rtl/cva5_fifo_flushable.sv
// cva5_fifo_flushable
// Synchronous FIFO with flush, occupancy count, almost-full threshold and an
// optional fall-through path when empty. Any DEPTH >= 1 is supported; the
// pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
//
// Handshake semantics (one place, used by every consumer of this block):
//   - valid/data_out present the head entry combinationally; a pop in a cycle
//     where valid=1 is accepted and the head advances at the next clock edge.
//   - A push is accepted when there is room, or when a pop is accepted in the
//     same cycle (the freed slot is reused, so a full FIFO streams).
//   - Requests that cannot be honoured are dropped and latched into the sticky
//     overflow_err / underflow_err flags; they have no other effect.
//   - flush wins over push/pop: the queue empties next cycle and the requests
//     of the flush cycle are silently discarded (no error flags).
//   - With BYPASS=1 and an empty queue, push&pop in the same cycle passes
//     data_in straight to data_out; nothing is stored.
module cva5_fifo_flushable #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = 3,
   parameter int BYPASS     = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        push,
   input  logic [DATA_WIDTH-1:0]       data_in,
   input  logic                        pop,
   output logic [DATA_WIDTH-1:0]       data_out,
   output logic                        valid,
   output logic                        full,
   output logic                        almost_full,
   output logic [$clog2(DEPTH+1)-1:0]  count,
   output logic                        overflow_err,
   output logic                        underflow_err
);

   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit BYP = (BYPASS != 0);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow_err;
   logic                  r_underflow_err;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_byp;
   logic                  w_pop_ok;
   logic                  w_push_ok;
   logic [CW-1:0]         w_count_next;
   logic [PW-1:0]         w_rd_ptr_next;
   logic [PW-1:0]         w_wr_ptr_next;

   // Explicit wrap so non-power-of-2 depths never index past the last entry.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Request qualification and next-state computation from registered count.
   always_comb begin
      w_empty       = (r_count == '0);
      w_full        = (r_count == CW'(DEPTH));
      w_byp         = BYP && w_empty && push && pop;
      w_pop_ok      = pop && (!w_empty || w_byp);
      w_push_ok     = push && (!w_full || w_pop_ok) && !w_byp;
      w_count_next  = r_count;
      w_rd_ptr_next = r_rd_ptr;
      w_wr_ptr_next = r_wr_ptr;
      if (flush) begin
         w_count_next  = '0;
         w_rd_ptr_next = '0;
         w_wr_ptr_next = '0;
      end else begin
         // A bypassed transfer never touches storage, pointers or count.
         if (w_push_ok) begin
            w_wr_ptr_next = ptr_inc(r_wr_ptr);
         end
         if (w_pop_ok && !w_byp) begin
            w_rd_ptr_next = ptr_inc(r_rd_ptr);
         end
         if (w_push_ok && !(w_pop_ok && !w_byp)) begin
            w_count_next = r_count + CW'(1);
         end else if (!w_push_ok && w_pop_ok && !w_byp) begin
            w_count_next = r_count - CW'(1);
         end
      end
   end

   // Pointers, occupancy and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_ptr        <= '0;
         r_wr_ptr        <= '0;
         r_count         <= '0;
         r_overflow_err  <= 1'b0;
         r_underflow_err <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_ptr_next;
         r_wr_ptr <= w_wr_ptr_next;
         r_count  <= w_count_next;
         if (push && !w_push_ok && !w_byp && !flush) begin
            r_overflow_err <= 1'b1;
         end
         if (pop && !w_pop_ok && !flush) begin
            r_underflow_err <= 1'b1;
         end
      end
   end

   // Entry storage; deliberately not reset, valid is derived from count.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && w_push_ok) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Head presentation and status flags, all from registered count.
   always_comb begin
      data_out      = r_mem[r_rd_ptr];
      if (BYP && w_empty) begin
         data_out = data_in;
      end
      valid         = !w_empty || (BYP && push && w_empty);
      full          = w_full;
      almost_full   = (r_count >= CW'(AF_THRESH));
      count         = r_count;
      overflow_err  = r_overflow_err;
      underflow_err = r_underflow_err;
   end

endmodule

// File: tb/tb_cva5_fifo_flushable.sv
// Bench for cva5_fifo_flushable: three instances (DEPTH=3 plain, DEPTH=3 with
// bypass, DEPTH=1) share one set of inputs; each scenario task checks one.
module tb_cva5_fifo_flushable;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         push = 1'b0;
   logic         pop = 1'b0;
   logic [W-1:0] din = '0;

   logic [W-1:0] a_dout, b_dout, c_dout;
   logic         a_valid, a_full, a_af, a_ovf, a_unf;
   logic         b_valid, b_full, b_af, b_ovf, b_unf;
   logic         c_valid, c_full, c_af, c_ovf, c_unf;
   logic [1:0]   a_count, b_count;
   logic [0:0]   c_count;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v;
   int           n_cmp = 0;
   int           n_err = 0;

   cva5_fifo_flushable #(.DATA_WIDTH(W), .DEPTH(3), .AF_THRESH(3), .BYPASS(0)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .data_in(din), .pop(pop),
      .data_out(a_dout), .valid(a_valid), .full(a_full), .almost_full(a_af),
      .count(a_count), .overflow_err(a_ovf), .underflow_err(a_unf));

   cva5_fifo_flushable #(.DATA_WIDTH(W), .DEPTH(3), .AF_THRESH(2), .BYPASS(1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .data_in(din), .pop(pop),
      .data_out(b_dout), .valid(b_valid), .full(b_full), .almost_full(b_af),
      .count(b_count), .overflow_err(b_ovf), .underflow_err(b_unf));

   cva5_fifo_flushable #(.DATA_WIDTH(W), .DEPTH(1), .AF_THRESH(1), .BYPASS(0)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .data_in(din), .pop(pop),
      .data_out(c_dout), .valid(c_valid), .full(c_full), .almost_full(c_af),
      .count(c_count), .overflow_err(c_ovf), .underflow_err(c_unf));

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 1'b0; pop = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic push_one(input logic [W-1:0] d);
      push = 1'b1; pop = 1'b0; din = d;
      exp_q.push_back(d);
      tick();
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (a_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", a_count); end
      n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", a_valid); end
      n_cmp++; if ({a_full, a_af, a_ovf, a_unf} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {a_full, a_af, a_ovf, a_unf}); end
   endtask

   task automatic test_fill_drain();
      do_reset();
      push_one($urandom);
      push_one($urandom);
      n_cmp++; if (a_af !== 1'b0) begin n_err++; $display("FAIL af_below_thresh got %b exp 0", a_af); end
      push_one($urandom);
      n_cmp++; if (a_full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", a_full); end
      n_cmp++; if (a_count !== 2'd3) begin n_err++; $display("FAIL fill_count got %0d exp 3", a_count); end
      n_cmp++; if (a_af !== 1'b1) begin n_err++; $display("FAIL af_at_thresh got %b exp 1", a_af); end
      for (int i = 0; i < 3; i++) begin
         exp_v = exp_q.pop_front();
         n_cmp++; if (a_valid !== 1'b1 || a_dout !== exp_v) begin n_err++; $display("FAIL drain_data[%0d] got %h/%b exp %h/1", i, a_dout, a_valid, exp_v); end
         pop = 1'b1;
         tick();
         idle();
      end
      n_cmp++; if (a_valid !== 1'b0 || a_count !== 2'd0) begin n_err++; $display("FAIL drain_empty got valid=%b count=%0d exp 0/0", a_valid, a_count); end
   endtask

   task automatic test_wrap();
      do_reset();
      push_one($urandom);
      push_one($urandom);
      for (int i = 0; i < 7; i++) begin
         din = $urandom; push = 1'b1; pop = 1'b1;
         #1;
         exp_v = exp_q.pop_front();
         n_cmp++; if (a_dout !== exp_v) begin n_err++; $display("FAIL wrap_data[%0d] got %h exp %h", i, a_dout, exp_v); end
         exp_q.push_back(din);
         tick();
         idle();
         n_cmp++; if (a_count !== 2'd2) begin n_err++; $display("FAIL wrap_count[%0d] got %0d exp 2", i, a_count); end
      end
      for (int i = 0; i < 2; i++) begin
         exp_v = exp_q.pop_front();
         n_cmp++; if (a_dout !== exp_v) begin n_err++; $display("FAIL wrap_tail[%0d] got %h exp %h", i, a_dout, exp_v); end
         pop = 1'b1;
         tick();
         idle();
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 3; i++) push_one($urandom);
      din = 32'hD0D0_D0D0; push = 1'b1; pop = 1'b1;
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++; if (a_dout !== exp_v) begin n_err++; $display("FAIL fullpp_head got %h exp %h", a_dout, exp_v); end
      exp_q.push_back(din);
      tick();
      idle();
      n_cmp++; if (a_count !== 2'd3 || a_ovf !== 1'b0) begin n_err++; $display("FAIL fullpp_state got count=%0d ovf=%b exp 3/0", a_count, a_ovf); end
      din = 32'hEEEE_EEEE; push = 1'b1;
      tick();
      idle();
      n_cmp++; if (a_count !== 2'd3 || a_ovf !== 1'b1) begin n_err++; $display("FAIL overflow got count=%0d ovf=%b exp 3/1", a_count, a_ovf); end
      for (int i = 0; i < 3; i++) begin
         exp_v = exp_q.pop_front();
         n_cmp++; if (a_dout !== exp_v) begin n_err++; $display("FAIL after_ovf_data[%0d] got %h exp %h", i, a_dout, exp_v); end
         pop = 1'b1;
         tick();
         idle();
      end
      n_cmp++; if (a_unf !== 1'b0) begin n_err++; $display("FAIL unf_premature got %b exp 0", a_unf); end
      pop = 1'b1;
      tick();
      idle();
      n_cmp++; if (a_unf !== 1'b1 || a_count !== 2'd0) begin n_err++; $display("FAIL underflow got unf=%b count=%0d exp 1/0", a_unf, a_count); end
   endtask

   task automatic test_flush();
      do_reset();
      push_one($urandom);
      push_one($urandom);
      flush = 1'b1; push = 1'b1; din = $urandom;
      tick();
      idle();
      exp_q.delete();
      n_cmp++; if (a_count !== 2'd0 || a_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty got count=%0d valid=%b exp 0/0", a_count, a_valid); end
      n_cmp++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_err++; $display("FAIL flush_err got %b%b exp 00", a_ovf, a_unf); end
      flush = 1'b1; pop = 1'b1;
      tick();
      idle();
      n_cmp++; if (a_unf !== 1'b0) begin n_err++; $display("FAIL flush_pop_unf got %b exp 0", a_unf); end
      push_one(32'hF00D_F00D);
      exp_v = exp_q.pop_front();
      n_cmp++; if (a_dout !== exp_v || a_valid !== 1'b1 || a_count !== 2'd1) begin n_err++; $display("FAIL post_flush got %h/%b/%0d exp %h/1/1", a_dout, a_valid, a_count, exp_v); end
   endtask

   task automatic test_bypass();
      do_reset();
      din = 32'h6666_1234; push = 1'b1; pop = 1'b1;
      #1;
      n_cmp++; if (b_valid !== 1'b1 || b_dout !== 32'h6666_1234) begin n_err++; $display("FAIL byp_same_cycle got %h/%b exp 66661234/1", b_dout, b_valid); end
      tick();
      idle();
      n_cmp++; if (b_count !== 2'd0 || b_ovf !== 1'b0 || b_unf !== 1'b0) begin n_err++; $display("FAIL byp_after got count=%0d ovf=%b unf=%b exp 0/0/0", b_count, b_ovf, b_unf); end
      pop = 1'b1;
      tick();
      idle();
      n_cmp++; if (b_unf !== 1'b1) begin n_err++; $display("FAIL byp_underflow got %b exp 1", b_unf); end
      push_one($urandom);
      push_one($urandom);
      n_cmp++; if (b_af !== 1'b1 || b_count !== 2'd2) begin n_err++; $display("FAIL byp_af got af=%b count=%0d exp 1/2", b_af, b_count); end
      exp_v = exp_q.pop_front();
      n_cmp++; if (b_dout !== exp_v) begin n_err++; $display("FAIL byp_stored_head got %h exp %h", b_dout, exp_v); end
   endtask

   task automatic test_af_reset();
      do_reset();
      for (int i = 0; i < 3; i++) push_one($urandom);
      push = 1'b1; din = $urandom;
      tick();
      idle();
      n_cmp++; if (a_af !== 1'b1 || a_ovf !== 1'b1) begin n_err++; $display("FAIL af_pre_reset got af=%b ovf=%b exp 1/1", a_af, a_ovf); end
      rst_n = 1'b0; push = 1'b1; pop = 1'b1;
      tick();
      rst_n = 1'b1;
      idle();
      exp_q.delete();
      n_cmp++; if (a_count !== 2'd0 || a_af !== 1'b0 || a_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset got count=%0d af=%b valid=%b exp 0/0/0", a_count, a_af, a_valid); end
      n_cmp++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin n_err++; $display("FAIL mid_reset_err got %b%b exp 00", a_ovf, a_unf); end
   endtask

   task automatic test_depth1();
      do_reset();
      push_one(32'h1111_0001);
      n_cmp++; if (c_full !== 1'b1 || c_valid !== 1'b1 || c_af !== 1'b1) begin n_err++; $display("FAIL d1_full got full=%b valid=%b af=%b exp 1/1/1", c_full, c_valid, c_af); end
      din = 32'h2222_0002; push = 1'b1; pop = 1'b1;
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++; if (c_dout !== exp_v) begin n_err++; $display("FAIL d1_head got %h exp %h", c_dout, exp_v); end
      exp_q.push_back(din);
      tick();
      idle();
      exp_v = exp_q.pop_front();
      n_cmp++; if (c_dout !== exp_v || c_count !== 1'b1 || c_ovf !== 1'b0) begin n_err++; $display("FAIL d1_stream got %h/%0d/%b exp %h/1/0", c_dout, c_count, c_ovf, exp_v); end
      push = 1'b1; din = $urandom;
      tick();
      idle();
      n_cmp++; if (c_ovf !== 1'b1 || c_dout !== exp_v) begin n_err++; $display("FAIL d1_overflow got ovf=%b data=%h exp 1/%h", c_ovf, c_dout, exp_v); end
      pop = 1'b1;
      tick();
      idle();
      n_cmp++; if (c_valid !== 1'b0 || c_full !== 1'b0) begin n_err++; $display("FAIL d1_empty got valid=%b full=%b exp 0/0", c_valid, c_full); end
   endtask

   // sequence + final report
   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_full_push_pop();
      test_flush();
      test_bypass();
      test_af_reset();
      test_depth1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
